// File: rtl/exwb_pkg.sv
// Shared types and widths for the execute-to-writeback buffer.
// Optional forwarding outputs are enabled with the EXWB_FWD_EN macro.
package exwb_pkg;

    localparam int unsigned DATA_W    = 32;
    localparam int unsigned REG_AW    = 5;
    localparam int unsigned DIFF_NONE = 32;

    typedef struct packed {
        logic [DATA_W-1:0] result;
        logic [REG_AW-1:0] rd;
        logic              we;
        logic              diff_none;
    } exwb_entry_t;

    typedef enum logic [1:0] {
        StEmpty,
        StOne,
        StFull
    } exwb_occ_e;

endpackage

// File: rtl/exwb_skid.sv
// Generic 2-entry valid/ready skid buffer with synchronous flush.
// in_ready is decoded from the occupancy register only, never from out_ready.
module exwb_skid
    import exwb_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    exwb_occ_e    state_q, state_d;
    logic [W-1:0] h_q, h_d;
    logic [W-1:0] s_q, s_d;
    logic         accept;
    logic         pop;

    assign in_ready  = (state_q != StFull);
    assign out_valid = (state_q != StEmpty);
    assign out_data  = h_q;
    assign accept    = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_comb begin
        state_d = state_q;
        h_d     = h_q;
        s_d     = s_q;
        if (flush) begin
            state_d = StEmpty;
        end else begin
            unique case (state_q)
                StEmpty: begin
                    if (accept) begin
                        h_d     = in_data;
                        state_d = StOne;
                    end
                end
                StOne: begin
                    if (accept && pop) begin
                        h_d = in_data;
                    end else if (accept) begin
                        s_d     = in_data;
                        state_d = StFull;
                    end else if (pop) begin
                        state_d = StEmpty;
                    end
                end
                StFull: begin
                    // in_ready is low here, so only a pop can move anything
                    if (pop) begin
                        h_d     = s_q;
                        state_d = StOne;
                    end
                end
                default: state_d = StEmpty;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StEmpty;
            h_q     <= '0;
            s_q     <= '0;
        end else begin
            state_q <= state_d;
            h_q     <= h_d;
            s_q     <= s_d;
        end
    end

endmodule

// File: rtl/ex_wb_stage.sv
// Execute-to-writeback pipeline buffer: qualifies results, buffers them, counts retired writes.
// Define EXWB_FWD_EN to add the fwd_* bypass outputs driven from the head entry.
module ex_wb_stage
    import exwb_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_result,
    input  logic [REG_AW-1:0] in_rd,
    input  logic              in_we,
    input  logic              in_is_diff,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic [REG_AW-1:0] out_rd,
    output logic              out_we,
    output logic              out_diff_none,
    output logic [31:0]       retire_cnt
`ifdef EXWB_FWD_EN
    ,
    output logic              fwd_valid,
    output logic [REG_AW-1:0] fwd_rd,
    output logic [DATA_W-1:0] fwd_data
`endif
);

    exwb_entry_t in_entry;
    exwb_entry_t head;
    logic        pop;
    logic [31:0] retire_cnt_q;

    // r0 is hardwired zero, so a write to it is dropped at capture
    always_comb begin
        in_entry           = '0;
        in_entry.result    = in_result;
        in_entry.rd        = in_rd;
        in_entry.we        = in_we && (in_rd != '0);
        in_entry.diff_none = in_is_diff && (in_result == DATA_W'(DIFF_NONE));
    end

    exwb_skid #(
        .W($bits(exwb_entry_t))
    ) u_skid (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_entry),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (head)
    );

    assign out_result    = head.result;
    assign out_rd        = head.rd;
    assign out_we        = head.we;
    assign out_diff_none = head.diff_none;
    assign pop           = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retire_cnt_q <= '0;
        end else if (pop && head.we && !flush) begin
            retire_cnt_q <= retire_cnt_q + 32'd1;
        end
    end

    assign retire_cnt = retire_cnt_q;

`ifdef EXWB_FWD_EN
    assign fwd_valid = out_valid && head.we;
    assign fwd_rd    = head.rd;
    assign fwd_data  = head.result;
`endif

endmodule

// File: doc/ex_wb_stage.md
Name: ex_wb_stage

Overview:
- Pipeline buffer between the execute stage (ALU, including the lowest-differing-bit "diff" unit) and register-file writeback.
- Captures each execute result with its destination register and write enable, and holds it under a valid/ready handshake.
- Absorbs one cycle of writeback back-pressure with a 2-entry skid buffer, so execute can run at one result per cycle.
- Flags diff results that found no differing bit (index 32) and counts retired register writes.

Parameters:
- DATA_W, 32, result/data width.
- REG_AW, 5, register address width (32 registers, r0 hardwired zero).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous discard of all buffered entries (branch taken).
- in_valid  in  1  execute result valid.
- in_ready  out  1  stage can accept a result.
- in_result  in  DATA_W  ALU/diff result.
- in_rd  in  REG_AW  destination register.
- in_we  in  1  result writes rd.
- in_is_diff  in  1  result came from the diff unit.
- out_valid  out  1  head entry valid.
- out_ready  in  1  writeback accepts head.
- out_result  out  DATA_W  head result.
- out_rd  out  REG_AW  head destination.
- out_we  out  1  head write enable, already qualified.
- out_diff_none  out  1  head is a diff result equal to 32 (operands identical).
- retire_cnt  out  32  count of retired entries with out_we=1.
- fwd_valid  out  1  (EXWB_FWD_EN only) forwarding data valid.
- fwd_rd  out  REG_AW  (EXWB_FWD_EN only) forwarding destination register.
- fwd_data  out  DATA_W  (EXWB_FWD_EN only) forwarding data.

Behaviour:
- Reset (rst_n low, asynchronous):
  - Both entries invalid; out_valid=0, in_ready=1.
  - out_result, out_rd, out_we, out_diff_none = 0; retire_cnt = 0; fwd_* = 0.
- Storage: head entry H feeds the outputs; skid entry S holds overflow. in_ready = !S.valid, driven from a register with no combinational path from out_ready.
- Accept occurs when in_valid && in_ready. Pop occurs when out_valid && out_ready.
- Capture qualification:
  - stored we = in_we && (in_rd != 0); writes to r0 are never issued.
  - stored diff_none = in_is_diff && (in_result == 32).
- Transitions, as (H.valid, S.valid):
  - EMPTY (0,0): accept → (1,0), data in H.
  - ONE (1,0):
    - accept only → (1,1), data in S.
    - pop only → (0,0).
    - accept and pop together → (1,0), H replaced by the new data.
  - FULL (1,1), in_ready=0:
    - pop → (1,0), S moves to H.
    - pop with in_valid high → new data is not accepted, because in_ready was 0.
- Latency: 1 cycle from accept to out_valid when empty. Throughput: 1 result per cycle while out_ready=1. Entries retire in strict arrival order.
- Head stability: H contents must not change while out_valid && !out_ready.
- Flush:
  - Next edge → (0,0).
  - An accept or pop in the same cycle is discarded and not counted.
  - in_ready=1 in the following cycle.
- retire_cnt: +1 on a pop with out_we=1 and no flush in that cycle; wraps 0xFFFFFFFF→0.
- Mid-operation reset returns all state to reset values immediately; no partial entry survives.

Optional Feature:
- Macro: EXWB_FWD_EN.
- Defined:
  - fwd_valid = H.valid && H.we; fwd_rd = H.rd; fwd_data = H.result. Combinational from H.
  - Lets the operand mux bypass a result before writeback.
- Not defined:
  - fwd_* ports are absent and no forwarding logic is built.
  - All other behaviour is identical.

Decomposition:
- Shared package exwb_pkg:
  - DATA_W and REG_AW defaults.
  - DIFF_NONE = 32.
  - Packed typedef exwb_entry_t {result, rd, we, diff_none}.
- One sub-module, exwb_skid: a generic 2-entry valid/ready skid buffer over exwb_entry_t, with flush.
- The top level does capture qualification, the retire counter and forwarding.

Test Plan:
- Reset then single result: in_result=0x5, rd=3, we=1, out_ready=1 → next cycle out_valid=1, out_result=0x5, out_rd=3; retire_cnt=1 after the pop.
- r0 write: rd=0, we=1 → out_we=0; retire_cnt is unchanged after the pop.
- Diff none: in_is_diff=1, in_result=32 → out_diff_none=1. With in_result=7 → out_diff_none=0.
- Back-pressure: out_ready=0, push A=1 then B=2 → in_ready=0 after B. Then out_ready=1 → A then B on consecutive cycles; no C is accepted while FULL.
- Flush while FULL with in_valid=1 → next cycle out_valid=0, in_ready=1, retire_cnt unchanged.
- Async reset asserted mid-stream while FULL → outputs zero immediately without waiting for a clock edge. With EXWB_FWD_EN defined, fwd_valid tracks H.valid && H.we each cycle.
